// File: rtl/fifo_read_stream_if.sv
// ---------------------------------------------------------------------------
// fifo_read_stream_if
//  Bundles the read-side signals of the async FIFO drain engine: the FIFO
//  storage handshake (fifo_empty/read_data/read_en), the outgoing valid/ready
//  stream (out_valid/out_ready/out_data) and the control/status pair
//  (drain_en/word_count).
//  master : drain engine side (drives read_en, out_valid, out_data, word_count)
//  slave  : environment side (FIFO storage + stream consumer + control)
// ---------------------------------------------------------------------------
interface fifo_read_stream_if #(
    parameter int data_size = 8,
    parameter int cnt_size  = 16
);
    logic                 fifo_empty;
    logic [data_size-1:0] read_data;
    logic                 read_en;
    logic                 out_valid;
    logic                 out_ready;
    logic [data_size-1:0] out_data;
    logic                 drain_en;
    logic [cnt_size-1:0]  word_count;

    modport master (
        input  fifo_empty, read_data, out_ready, drain_en,
        output read_en, out_valid, out_data, word_count
    );

    modport slave (
        output fifo_empty, read_data, out_ready, drain_en,
        input  read_en, out_valid, out_data, word_count
    );
endinterface

// File: rtl/fifo_read_stream.sv
// ---------------------------------------------------------------------------
// fifo_read_stream
//  Read-clock-domain drain engine for the async FIFO. Pops words from FIFO
//  storage, absorbs its one-cycle registered read latency in a 3-entry skid
//  buffer and presents them on a valid/ready stream at up to 1 word/cycle.
//  read_en depends only on registers, drain_en and fifo_empty, never on
//  out_ready, so there is no combinational path from the consumer back to
//  the FIFO.
//
//  Ports
//   read_clk    in   read-domain clock (posedge)
//   read_rst_n  in   asynchronous active-low reset
//   bus         fifo_read_stream_if.master
//     fifo_empty in  / read_data in  / read_en out      FIFO storage side
//     out_valid out  / out_ready in  / out_data out     output stream
//     drain_en   in  / word_count out                   control / status
// ---------------------------------------------------------------------------
module fifo_read_stream #(
    parameter int data_size = 8,
    parameter int cnt_size  = 16
) (
    input  logic                       read_clk,
    input  logic                       read_rst_n,
    fifo_read_stream_if.master         bus
);

    logic [data_size-1:0] r_mem [0:2];
    logic [1:0]           r_head;
    logic [1:0]           r_tail;
    logic [1:0]           r_count;
    logic                 r_pending;
    logic [cnt_size-1:0]  r_word_count;

    logic                 w_credit_ok;
    logic                 w_read_en;
    logic                 w_push;
    logic                 w_pop;
    logic [1:0]           w_head_nxt;
    logic [1:0]           w_tail_nxt;

    // A read is only issued when its word is guaranteed a buffer slot:
    // words already buffered plus the one in flight must leave room.
    // Gating with read_rst_n keeps read_en low while reset is held.
    assign w_credit_ok = ({1'b0, r_count} + {2'b00, r_pending}) < 3'd3;
    assign w_read_en   = read_rst_n && bus.drain_en && !bus.fifo_empty && w_credit_ok;

    // read_data is only looked at when a qualified read was issued last cycle.
    assign w_push = r_pending;
    assign w_pop  = (r_count != 2'd0) && bus.out_ready;

    assign w_head_nxt = (r_head == 2'd2) ? 2'd0 : r_head + 2'd1;
    assign w_tail_nxt = (r_tail == 2'd2) ? 2'd0 : r_tail + 2'd1;

    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            for (int i = 0; i < 3; i++) r_mem[i] <= '0;
            r_head       <= 2'd0;
            r_tail       <= 2'd0;
            r_count      <= 2'd0;
            r_pending    <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_pending <= w_read_en && !bus.fifo_empty;
            if (w_push) begin
                r_mem[r_tail] <= bus.read_data;
                r_tail        <= w_tail_nxt;
            end
            if (w_pop) begin
                r_head       <= w_head_nxt;
                r_word_count <= r_word_count + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.read_en    = w_read_en;
    assign bus.out_valid  = (r_count != 2'd0);
    assign bus.out_data   = r_mem[r_head];
    assign bus.word_count = r_word_count;

    // The credit rule must make a push into a full buffer impossible.
    a_no_overflow: assert property (@(posedge read_clk) disable iff (!read_rst_n)
        !(w_push && !w_pop && (r_count == 2'd3)));

endmodule
